// File: rtl/burst_memory_if.sv
// burst_memory_if: request/response channel bundle for burst_memory.
//   req_*  : command and write-data beats, valid/ready handshake (master -> slave)
//   resp_* : read-data / write-ack beats, valid/ready handshake (slave -> master)
// Modports: master (cache side, drives requests), slave (memory side).
interface burst_memory_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wen;
  logic                    req_burst;
  logic [ADDR_WIDTH-1:0]   req_address;
  logic [DATA_WIDTH-1:0]   req_data;
  logic [DATA_WIDTH/8-1:0] req_strobe;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    resp_last;
  logic                    resp_error;

  modport master (
    output req_valid, req_wen, req_burst, req_address, req_data, req_strobe, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_last, resp_error
  );

  modport slave (
    input  req_valid, req_wen, req_burst, req_address, req_data, req_strobe, resp_ready,
    output req_ready, resp_valid, resp_data, resp_last, resp_error
  );
endinterface

// File: rtl/burst_memory.sv
// burst_memory: cycle-approximate main-memory model behind a cache refill/writeback port.
// Supports single-beat and wrapping (critical-word-first) bursts of BURST_LEN beats,
// a fixed LATENCY before the first response beat, byte strobes on writes, and an
// error flag for word indices >= DEPTH (no aliasing, no array access).
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - burst_memory_if.slave: req_* command/write beats, resp_* read/ack beats
module burst_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned LATENCY    = 4
) (
  input logic             clk,
  input logic             rst,
  burst_memory_if.slave   bus
);

  localparam int unsigned OFF = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WW  = ADDR_WIDTH - OFF;
  localparam int unsigned BB  = $clog2(BURST_LEN);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned NB  = DATA_WIDTH / 8;

  typedef enum logic [2:0] {StIdle, StWdata, StWait, StRdata, StWresp} state_e;

  state_e                state_q;
  logic                  wen_q;
  logic                  burst_q;
  logic [WW-1:0]         addr_q;
  logic                  err_q;
  logic [BB-1:0]         beat_q;
  logic [LW-1:0]         lat_q;
  logic                  resp_valid_q;
  logic                  resp_last_q;
  logic                  resp_error_q;
  logic [DATA_WIDTH-1:0] resp_data_q;

  // Contents start at zero and are never reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [WW-1:0]         wi_in;
  logic                  err_in;
  logic                  unused_addr;
  logic                  wr_en;
  logic [AW-1:0]         wr_idx;
  logic [BB-1:0]         rd_beat;
  logic [AW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // Replace the low BB bits of a word index with (low + beat) mod BURST_LEN.
  function automatic logic [WW-1:0] wrap(input logic [WW-1:0] base, input logic [BB-1:0] beat);
    logic [BB-1:0] low;
    low = base[BB-1:0] + beat;
    return {base[WW-1:BB], low};
  endfunction

  assign wi_in       = bus.req_address[ADDR_WIDTH-1:OFF];
  assign err_in      = 32'(wi_in) >= DEPTH;
  // Byte-offset bits are intentionally ignored.
  assign unused_addr = ^bus.req_address;

  // Gating with rst drops req_ready the instant reset is asserted.
  assign bus.req_ready = !rst && (state_q == StIdle || state_q == StWdata);

  // Write port: the command beat writes beat 0, WDATA beats write the following wrapped words.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = AW'(wi_in);
    if (bus.req_valid && bus.req_ready) begin
      if (state_q == StIdle) begin
        wr_en  = bus.req_wen && !err_in;
        wr_idx = AW'(wi_in);
      end else if (state_q == StWdata) begin
        wr_en  = !err_q;
        wr_idx = AW'(wrap(addr_q, beat_q));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.req_strobe[b]) mem[wr_idx][8*b +: 8] <= bus.req_data[8*b +: 8];
      end
    end
  end

  // Read port: in WAIT the first beat is fetched, in RDATA the beat after the current one.
  always_comb begin
    rd_beat = (state_q == StRdata) ? beat_q + BB'(1) : '0;
    rd_idx  = AW'(wrap(addr_q, rd_beat));
    rd_word = mem[rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wen_q        <= 1'b0;
      burst_q      <= 1'b0;
      addr_q       <= '0;
      err_q        <= 1'b0;
      beat_q       <= '0;
      lat_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            wen_q   <= bus.req_wen;
            burst_q <= bus.req_burst;
            addr_q  <= wi_in;
            err_q   <= err_in;
            lat_q   <= '0;
            if (bus.req_wen && bus.req_burst) begin
              state_q <= StWdata;
              beat_q  <= BB'(1);
            end else begin
              state_q <= StWait;
              beat_q  <= '0;
            end
          end
        end
        StWdata: begin
          if (bus.req_valid) begin
            if (beat_q == BB'(BURST_LEN - 1)) begin
              state_q <= StWait;
              beat_q  <= '0;
              lat_q   <= '0;
            end else begin
              beat_q <= beat_q + BB'(1);
            end
          end
        end
        StWait: begin
          if (lat_q == LW'(LATENCY - 1)) begin
            resp_valid_q <= 1'b1;
            resp_error_q <= err_q;
            if (wen_q) begin
              state_q     <= StWresp;
              resp_last_q <= 1'b1;
              resp_data_q <= '0;
            end else begin
              state_q     <= StRdata;
              resp_last_q <= !burst_q;
              resp_data_q <= err_q ? '0 : rd_word;
            end
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        StRdata: begin
          // Outputs hold while valid && !ready.
          if (bus.resp_ready) begin
            if (resp_last_q) begin
              state_q      <= StIdle;
              resp_valid_q <= 1'b0;
              resp_last_q  <= 1'b0;
              resp_error_q <= 1'b0;
              resp_data_q  <= '0;
            end else begin
              beat_q      <= rd_beat;
              resp_last_q <= (rd_beat == BB'(BURST_LEN - 1));
              resp_data_q <= err_q ? '0 : rd_word;
            end
          end
        end
        StWresp: begin
          if (bus.resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_error_q <= 1'b0;
            resp_data_q  <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_last  = resp_last_q;
  assign bus.resp_error = resp_error_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_burst_memory.sv
// tb_burst_memory: directed self-checking bench for burst_memory (default parameters).
module tb_burst_memory;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 16;
  localparam int unsigned DEP = 4096;
  localparam int unsigned BL  = 4;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  burst_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  burst_memory #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEP),
    .BURST_LEN (BL),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request beat (from a negedge) and hold it until accepted.
  task automatic send_beat(input logic wen, input logic burst, input logic [15:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    bus.req_valid   = 1'b1;
    bus.req_wen     = wen;
    bus.req_burst   = burst;
    bus.req_address = addr;
    bus.req_data    = data;
    bus.req_strobe  = strb;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("req_ready_timeout", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int waited);
    waited = 0;
    while (!bus.resp_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.resp_valid) check("resp_valid_timeout", {31'b0, bus.resp_valid}, 32'd1);
  endtask

  // Check one response beat, then let it be consumed (resp_ready is expected high).
  task automatic take_beat(input string tag, input logic [31:0] exp_data, input logic exp_last,
                           input logic exp_err, output int waited);
    wait_resp(waited);
    check({tag, "_data"}, bus.resp_data, exp_data);
    check({tag, "_last"}, {31'b0, bus.resp_last}, {31'b0, exp_last});
    check({tag, "_err"}, {31'b0, bus.resp_error}, {31'b0, exp_err});
    @(negedge clk);
  endtask

  task automatic write1(input string tag, input logic [15:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
    int w;
    send_beat(1'b1, 1'b0, addr, data, strb);
    take_beat({tag, "_ack"}, 32'h0, 1'b1, 1'b0, w);
  endtask

  task automatic read1(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    int w;
    send_beat(1'b0, 1'b0, addr, 32'h0, 4'h0);
    take_beat(tag, exp, 1'b1, 1'b0, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [31:0] exp_burst [4];
    bus.req_valid   = 1'b0;
    bus.req_wen     = 1'b0;
    bus.req_burst   = 1'b0;
    bus.req_address = '0;
    bus.req_data    = '0;
    bus.req_strobe  = '0;
    bus.resp_ready  = 1'b1;

    // Reset state.
    #2;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_last", {31'b0, bus.resp_last}, 32'd0);
    check("rst_resp_error", {31'b0, bus.resp_error}, 32'd0);
    check("rst_resp_data", bus.resp_data, 32'h0);
    check("rst_req_ready_hold", {31'b0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);

    // Single write then read with latency measurement.
    send_beat(1'b1, 1'b0, 16'h0014, 32'hDEADBEEF, 4'hF);
    take_beat("t1_wack", 32'h0, 1'b1, 1'b0, w);
    check("t1_wack_latency", w, LAT);
    send_beat(1'b0, 1'b0, 16'h0014, 32'h0, 4'h0);
    take_beat("t1_rd", 32'hDEADBEEF, 1'b1, 1'b0, w);
    check("t1_rd_latency", w, LAT);
    check("t1_ready_after", {31'b0, bus.req_ready}, 32'd1);
    check("t1_valid_after", {31'b0, bus.resp_valid}, 32'd0);

    // Strobed write: bytes 0 and 2 only.
    write1("t2_pre", 16'h000C, 32'h11223344, 4'hF);
    write1("t2_strb", 16'h000C, 32'hAABBCCDD, 4'b0101);
    read1("t2_rd", 16'h000C, 32'h11BB33DD);

    // Burst write words 0..3, then wrapping burst read from word 2.
    send_beat(1'b1, 1'b1, 16'h0000, 32'h000000A0, 4'hF);
    send_beat(1'b1, 1'b1, 16'hFFFF, 32'h000000A1, 4'hF);
    send_beat(1'b1, 1'b1, 16'hFFFF, 32'h000000A2, 4'hF);
    send_beat(1'b1, 1'b1, 16'hFFFF, 32'h000000A3, 4'hF);
    take_beat("t3_wack", 32'h0, 1'b1, 1'b0, w);
    check("t3_wack_latency", w, LAT);
    exp_burst[0] = 32'hA2;
    exp_burst[1] = 32'hA3;
    exp_burst[2] = 32'hA0;
    exp_burst[3] = 32'hA1;
    send_beat(1'b0, 1'b1, 16'h0008, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      take_beat($sformatf("t3_b%0d", i), exp_burst[i], i == 3, 1'b0, w);
      if (i > 0) check($sformatf("t3_gap%0d", i), w, 0);
    end

    // Same burst with backpressure on beat 1.
    send_beat(1'b0, 1'b1, 16'h0008, 32'h0, 4'h0);
    take_beat("t4_b0", 32'hA2, 1'b0, 1'b0, w);
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_hold_valid%0d", i), {31'b0, bus.resp_valid}, 32'd1);
      check($sformatf("t4_hold_data%0d", i), bus.resp_data, 32'hA3);
      check($sformatf("t4_hold_last%0d", i), {31'b0, bus.resp_last}, 32'd0);
      check($sformatf("t4_hold_rdy%0d", i), {31'b0, bus.req_ready}, 32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    take_beat("t4_b1", 32'hA3, 1'b0, 1'b0, w);
    take_beat("t4_b2", 32'hA0, 1'b0, 1'b0, w);
    check("t4_gap2", w, 0);
    take_beat("t4_b3", 32'hA1, 1'b1, 1'b0, w);
    check("t4_gap3", w, 0);

    // Out-of-range burst read and single write.
    send_beat(1'b0, 1'b1, 16'h4000, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) take_beat($sformatf("t5_b%0d", i), 32'h0, i == 3, 1'b1, w);
    send_beat(1'b1, 1'b0, 16'h4000, 32'hFFFFFFFF, 4'hF);
    take_beat("t5_wack", 32'h0, 1'b1, 1'b1, w);
    read1("t5_word0", 16'h0000, 32'hA0);

    // Reset in the middle of a burst write to words 8..11.
    write1("t6_pre10", 16'h0028, 32'h55555555, 4'hF);
    write1("t6_pre11", 16'h002C, 32'h66666666, 4'hF);
    send_beat(1'b1, 1'b1, 16'h0020, 32'h000000B0, 4'hF);
    send_beat(1'b1, 1'b1, 16'h0020, 32'h000000B1, 4'hF);
    bus.req_valid   = 1'b1;
    bus.req_data    = 32'h000000B2;
    bus.req_strobe  = 4'hF;
    check("t6_ready_pre", {31'b0, bus.req_ready}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_ready_rst", {31'b0, bus.req_ready}, 32'd0);
    check("t6_valid_rst", {31'b0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("t6_ready_after", {31'b0, bus.req_ready}, 32'd1);
    read1("t6_w8", 16'h0020, 32'hB0);
    read1("t6_w9", 16'h0024, 32'hB1);
    read1("t6_w10", 16'h0028, 32'h55555555);
    read1("t6_w11", 16'h002C, 32'h66666666);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_memory.md
Name: burst_memory

Overview:
- Parametrised, cycle-approximate main-memory model that sits behind the cache's refill/writeback port.
- Generalises the single-word fixed-delay memory in three ways:
  - configurable data width, depth and latency;
  - valid/ready handshakes on both the request and response channels;
  - wrapping (critical-word-first) bursts of BURST_LEN beats for cache-line fills and writebacks.
- Out-of-range accesses are reported through an error flag instead of aliasing.

Parameters:
DATA_WIDTH, 32, beat width in bits; multiple of 8.
ADDR_WIDTH, 16, byte-address width.
DEPTH, 4096, number of DATA_WIDTH words implemented; word index >= DEPTH is out of range.
BURST_LEN, 4, beats per burst; power of two, >= 2.
LATENCY, 4, cycles from command acceptance (read) or last write beat to first response beat; >= 1.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  request beat valid
req_ready  output  1  request beat accepted when valid&ready
req_wen  input  1  1=write, 0=read; sampled on command beat only
req_burst  input  1  1=BURST_LEN beats, 0=single beat; sampled on command beat only
req_address  input  ADDR_WIDTH  byte address; sampled on command beat only
req_data  input  DATA_WIDTH  write data, every write beat
req_strobe  input  DATA_WIDTH/8  byte enables, every write beat
resp_valid  output  1  response beat valid
resp_ready  input  1  response beat consumed when valid&ready
resp_data  output  DATA_WIDTH  read data; 0 for write acks and errors
resp_last  output  1  final beat of response
resp_error  output  1  command address out of range

Behaviour:
- Word index:
  - WI = req_address[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits are ignored.
  - Beat i of a burst uses WI with its low log2(BURST_LEN) bits replaced by (WI_low + i) mod BURST_LEN, i.e. a wrapping burst inside the aligned block.
- Error:
  - Checked once, on the command beat: error = (WI >= DEPTH).
  - If set, no array access occurs for the whole transaction.
  - All response beats carry resp_error=1 and resp_data=0.
- Reset (async):
  - State IDLE; beat/latency counters 0.
  - resp_valid, resp_last, resp_error = 0; resp_data = 0; req_ready = 0 while rst is high.
  - Array contents are not reset; they are initialised to 0 at time zero.
  - Reset mid-transaction abandons the transaction. Write beats already accepted stay committed.
- States: IDLE, WDATA, WAIT, RDATA, WRESP.
- IDLE:
  - req_ready=1.
  - On handshake, latch wen/burst/address/error.
  - Write: beat 0 is written using strobes. Burst goes to WDATA; single goes to WAIT.
  - Read: go to WAIT.
- WDATA:
  - req_ready=1.
  - Each handshake writes the next wrapped word with strobes. req_wen, req_burst and req_address are ignored.
  - After beat BURST_LEN-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter runs LATENCY cycles, so resp_valid first rises exactly LATENCY cycles after the accepting edge (read) or the last-write-beat edge (write).
  - Exits to RDATA (read) or WRESP (write).
- RDATA:
  - resp_data is registered, from the current wrapped word.
  - resp_valid stays high while beats remain. Beat advances only on resp_valid&resp_ready.
  - resp_data, resp_last and resp_error are held stable while valid&!ready. No bubbles between beats under constant resp_ready.
  - resp_last=1 on beat BURST_LEN-1 (burst) or beat 0 (single).
  - Last handshake returns to IDLE; resp_valid drops the next cycle.
- WRESP:
  - One beat: resp_valid=1, resp_last=1, resp_data=0.
  - Held until resp_ready; then IDLE.
- Request handling:
  - Only one transaction in flight; req_ready=0 in WAIT, RDATA and WRESP.
  - A request presented during those states waits. Its fields must stay stable until accepted.
- Strobes: byte b is written iff req_strobe[b]=1. All-zero strobe is a legal no-op beat.
- Read data returns array contents as of the cycle the beat is first presented. Write-then-read ordering is guaranteed by the single-transaction rule.

Test Plan:
- Single read, LATENCY=4: write WI=5 with 0xDEADBEEF, strobe 0xF; read address 0x14 accepted at edge T -> resp_valid first high at T+4, resp_data=0xDEADBEEF, resp_last=1, resp_error=0, req_ready back high the cycle after the response handshake.
- Strobed write: preload word 3 = 0x11223344; write 0xAABBCCDD with strobe 0b0101 to 0x0C -> one ack beat (data 0, last 1); subsequent read returns 0x11BB33DD.
- Wrapping burst read: words 0..3 = 0xA0..0xA3; burst read at byte 0x08 -> beats 0xA2, 0xA3, 0xA0, 0xA1 on consecutive cycles with resp_ready=1; resp_last only on 4th beat.
- Backpressure: same burst with resp_ready low for 3 cycles on beat 1 -> resp_data stays 0xA3 and resp_valid stays 1 throughout; no beat lost or duplicated; req_ready stays 0.
- Out-of-range: DEPTH=4096, burst read at byte 0x4000 -> 4 beats, each resp_error=1, resp_data=0; array unchanged. Also single write there -> ack with resp_error=1.
- Reset mid-burst-write: assert rst asynchronously after write beat 2 of 4 -> resp_valid/req_ready drop immediately; after release req_ready=1 in IDLE; beats 0–1 are committed, beats 2–3 are not.
